// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for a 5-stage pipeline with multi-cycle data memory.
// Define PIPE_FORWARDING_EN to enable operand forwarding (RAW stalls only on load-use).
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic [REG_AW-1:0] idex_rs_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic              idex_regwrite_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic              exmem_memacc_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              exmem_hold_o,
    output logic              memwb_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    localparam bit         MULTI     = (MEM_LAT > 1);
    localparam logic [2:0] WCNT_INIT = MULTI ? 3'(MEM_LAT - 2) : 3'd0;

    state_e             state_q;
    logic [2:0]         wcnt_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic               active;
    logic               mem_hold;
    logic               raw_hazard;
    logic [1:0]         fwd_a_sel;
    logic [1:0]         fwd_b_sel;

    function automatic logic writer_hit(input logic              we,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rt,
                                        input logic              uses_rt);
        return we && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    assign active   = start_i & ~rst_i;
    assign mem_hold = active & ((MULTI & (state_q == StRun) & exmem_memacc_i) |
                                ((state_q == StMemWait) & (wcnt_q != 3'd0)));

`ifdef PIPE_FORWARDING_EN
    assign raw_hazard = idex_memread_i &
                        writer_hit(idex_regwrite_i, idex_rd_i, ifid_rs_i, ifid_rt_i,
                                   ifid_uses_rt_i);

    // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (writer_hit(exmem_regwrite_i, exmem_rd_i, idex_rs_i, idex_rs_i, 1'b0)) begin
            fwd_a_sel = 2'b10;
        end else if (writer_hit(memwb_regwrite_i, memwb_rd_i, idex_rs_i, idex_rs_i, 1'b0)) begin
            fwd_a_sel = 2'b01;
        end
        if (writer_hit(exmem_regwrite_i, exmem_rd_i, idex_rt_i, idex_rt_i, 1'b0)) begin
            fwd_b_sel = 2'b10;
        end else if (writer_hit(memwb_regwrite_i, memwb_rd_i, idex_rt_i, idex_rt_i, 1'b0)) begin
            fwd_b_sel = 2'b01;
        end
    end
`else
    // Register file is not write-through, so a WB writer still hazards.
    assign raw_hazard =
        writer_hit(idex_regwrite_i, idex_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i) |
        writer_hit(exmem_regwrite_i, exmem_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i) |
        writer_hit(memwb_regwrite_i, memwb_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{idex_memread_i, idex_rs_i, idex_rt_i};
`endif

    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;
        fwd_a_o        = 2'b00;
        fwd_b_o        = 2'b00;
        if (active) begin
            if (mem_hold) begin
                exmem_hold_o   = 1'b1;
                memwb_bubble_o = 1'b1;
            end else if (raw_hazard) begin
                idex_bubble_o = 1'b1;
                fwd_a_o       = fwd_a_sel;
                fwd_b_o       = fwd_b_sel;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i | jump_i;
                fwd_a_o      = fwd_a_sel;
                fwd_b_o      = fwd_b_sel;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            wcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
        end else if (start_i) begin
            case (state_q)
                StRun: begin
                    if (mem_hold) begin
                        state_q <= StMemWait;
                        wcnt_q  <= WCNT_INIT;
                    end
                end
                StMemWait: begin
                    // The release cycle returns to StRun without re-arming on the same access.
                    if (wcnt_q != 3'd0) begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end else begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
            if (!pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: remaining-hold-cycle model compared every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic ifid_uses_rt, idex_regwrite, idex_memread, exmem_regwrite, exmem_memacc;
    logic memwb_regwrite, branch_taken, jump;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
        .idex_rs_i(idex_rs), .idex_rt_i(idex_rt), .idex_regwrite_i(idex_regwrite),
        .idex_memread_i(idex_memread), .idex_rd_i(idex_rd),
        .exmem_regwrite_i(exmem_regwrite), .exmem_memacc_i(exmem_memacc),
        .exmem_rd_i(exmem_rd), .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd),
        .branch_taken_i(branch_taken), .jump_i(jump),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .exmem_hold_o(exmem_hold),
        .memwb_bubble_o(memwb_bubble), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .stall_cnt_o(stall_cnt)
    );

    // ---------------- model: counts remaining hold cycles of the current access -------------
    int  m_left;
    bit  m_rel;
    int  m_cnt;
    int  m_nxt_left;
    bit  e_active, e_hold, e_raw;
    int  e_pc, e_ifw, e_flush, e_bub, e_exh, e_mwb, e_fa, e_fb, sel_a, sel_b;

    function automatic bit hit(input bit we, input int rd, input int rs, input int rt,
                               input bit uses);
        return we && rd != 0 && (rd == rs || (uses && rd == rt));
    endfunction

    always_comb begin
        e_active = start && !rst;
        e_hold   = e_active && (m_left > 0 ||
                   (LAT > 1 && exmem_memacc && m_left == 0 && !m_rel));
        sel_a = 0;
        sel_b = 0;
        if (FWD) begin
            e_raw = idex_memread && hit(idex_regwrite, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt);
            if (hit(exmem_regwrite, exmem_rd, idex_rs, idex_rs, 1'b0)) sel_a = 2;
            else if (hit(memwb_regwrite, memwb_rd, idex_rs, idex_rs, 1'b0)) sel_a = 1;
            if (hit(exmem_regwrite, exmem_rd, idex_rt, idex_rt, 1'b0)) sel_b = 2;
            else if (hit(memwb_regwrite, memwb_rd, idex_rt, idex_rt, 1'b0)) sel_b = 1;
        end else begin
            e_raw = hit(idex_regwrite, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt) ||
                    hit(exmem_regwrite, exmem_rd, ifid_rs, ifid_rt, ifid_uses_rt) ||
                    hit(memwb_regwrite, memwb_rd, ifid_rs, ifid_rt, ifid_uses_rt);
        end
        e_pc    = (e_active && !e_hold && !e_raw) ? 1 : 0;
        e_ifw   = e_pc;
        e_flush = (e_pc == 1 && (branch_taken || jump)) ? 1 : 0;
        e_bub   = (e_active && !e_hold && e_raw) ? 1 : 0;
        e_exh   = e_hold ? 1 : 0;
        e_mwb   = e_hold ? 1 : 0;
        e_fa    = (e_active && !e_hold) ? sel_a : 0;
        e_fb    = (e_active && !e_hold) ? sel_b : 0;
        m_nxt_left = (m_left > 0 ? m_left : LAT - 1) - 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_rel  <= 1'b0;
            m_cnt  <= 0;
        end else if (start) begin
            if (e_hold) begin
                m_left <= m_nxt_left;
                m_rel  <= (m_nxt_left == 0);
            end else begin
                m_rel <= 1'b0;
            end
            if (e_pc == 0 && m_cnt < CMAX) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("pc_write", int'(pc_write), e_pc);
        chk("ifid_write", int'(ifid_write), e_ifw);
        chk("ifid_flush", int'(ifid_flush), e_flush);
        chk("idex_bubble", int'(idex_bubble), e_bub);
        chk("exmem_hold", int'(exmem_hold), e_exh);
        chk("memwb_bubble", int'(memwb_bubble), e_mwb);
        chk("fwd_a", int'(fwd_a), e_fa);
        chk("fwd_b", int'(fwd_b), e_fb);
        chk("stall_cnt", int'(stall_cnt), m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        start = 1'b1;
        {ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd} = '0;
        {ifid_uses_rt, idex_regwrite, idex_memread, exmem_regwrite, exmem_memacc} = '0;
        {memwb_regwrite, branch_taken, jump} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        #2 chk("lit_rst_pc", int'(pc_write), 0);
        chk("lit_rst_cnt", int'(stall_cnt), 0);
        tick();
        tick();
        rst = 1'b0;
        #1 chk("lit_run_pc", int'(pc_write), 1);
        chk("lit_run_ifw", int'(ifid_write), 1);
        tick();

`ifdef PIPE_FORWARDING_EN
        // load-use: lw $2 in EX, add $3,$2,$4 in ID
        idex_regwrite = 1'b1; idex_memread = 1'b1; idex_rd = 5'd2;
        ifid_rs = 5'd2; ifid_rt = 5'd4; ifid_uses_rt = 1'b1;
        #1 chk("lit_lu_pc", int'(pc_write), 0);
        chk("lit_lu_bub", int'(idex_bubble), 1);
        tick();
        chk("lit_lu_cnt", int'(stall_cnt), 1);
        // lw now in MEM: memory hold for LAT-1 cycles, add waits in ID without stalling
        idex_regwrite = 1'b0; idex_memread = 1'b0; idex_rd = 5'd0;
        exmem_regwrite = 1'b1; exmem_rd = 5'd2; exmem_memacc = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            #1 chk("lit_lw_hold", int'(exmem_hold), 1);
            tick();
        end
        #1 chk("lit_lw_release", int'(pc_write), 1);
        tick();
        chk("lit_lw_cnt", int'(stall_cnt), 4);
        // add in EX, lw in WB
        clr();
        idex_rs = 5'd2; idex_rt = 5'd4; idex_regwrite = 1'b1; idex_rd = 5'd3;
        memwb_regwrite = 1'b1; memwb_rd = 5'd2;
        #1 chk("lit_fwd_wb", int'(fwd_a), 1);
        chk("lit_fwd_b0", int'(fwd_b), 0);
        tick();
        // non-load producer in EX: forwarded, no stall
        clr();
        idex_regwrite = 1'b1; idex_rd = 5'd2; ifid_rs = 5'd2;
        #1 chk("lit_alu_nostall", int'(pc_write), 1);
        tick();
        // both EX/MEM and MEM/WB write $5
        clr();
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; memwb_regwrite = 1'b1; memwb_rd = 5'd5;
        idex_rs = 5'd5; idex_rt = 5'd5;
        #1 chk("lit_fwd_a_ex", int'(fwd_a), 2);
        chk("lit_fwd_b_ex", int'(fwd_b), 2);
        tick();
        exmem_rd = 5'd0;
        #1 chk("lit_fwd_a_rd0", int'(fwd_a), 1);
        tick();
        memwb_rd = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
        #1 chk("lit_fwd_zero", int'(fwd_a), 0);
        chk("lit_fwd_zero_pc", int'(pc_write), 1);
        tick();
`else
        // ID reads $7; writer walks EX -> MEM -> WB
        ifid_rs = 5'd7;
        idex_regwrite = 1'b1; idex_rd = 5'd7;
        #1 chk("lit_ex_stall", int'(pc_write), 0);
        chk("lit_ex_bub", int'(idex_bubble), 1);
        tick();
        idex_regwrite = 1'b0; idex_rd = 5'd0; exmem_regwrite = 1'b1; exmem_rd = 5'd7;
        #1 chk("lit_mem_stall", int'(pc_write), 0);
        tick();
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; memwb_regwrite = 1'b1; memwb_rd = 5'd7;
        #1 chk("lit_wb_stall", int'(pc_write), 0);
        tick();
        memwb_regwrite = 1'b0; memwb_rd = 5'd0;
        #1 chk("lit_clear_pc", int'(pc_write), 1);
        chk("lit_cnt3", int'(stall_cnt), 3);
        tick();
        // rt counts only when used
        clr();
        ifid_rt = 5'd9; ifid_uses_rt = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd9;
        #1 chk("lit_rt_used", int'(pc_write), 0);
        tick();
        ifid_uses_rt = 1'b0;
        #1 chk("lit_rt_unused", int'(pc_write), 1);
        tick();
        // $0 never hazards
        clr();
        idex_regwrite = 1'b1; exmem_regwrite = 1'b1;
        #1 chk("lit_r0", int'(pc_write), 1);
        chk("lit_r0_fwd", int'(fwd_a), 0);
        tick();
`endif

        // store in MEM: LAT-1 hold cycles
        clr();
        exmem_memacc = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            #1 chk("lit_sw_hold", int'(exmem_hold), 1);
            chk("lit_sw_mwb", int'(memwb_bubble), 1);
            tick();
        end
        #1 chk("lit_sw_pc", int'(pc_write), 1);
        chk("lit_sw_hold_off", int'(exmem_hold), 0);
        tick();

        // taken branch during hold: flush only after release
        clr();
        exmem_memacc = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            #1 chk("lit_br_noflush", int'(ifid_flush), 0);
            tick();
        end
        #1 chk("lit_br_flush", int'(ifid_flush), 1);
        tick();
        clr();
        jump = 1'b1;
        #1 chk("lit_jump_flush", int'(ifid_flush), 1);
        tick();

        // start_i low in the middle of a wait freezes everything
        clr();
        exmem_memacc = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("lit_idle_pc", int'(pc_write), 0);
        chk("lit_idle_hold", int'(exmem_hold), 0);
        tick();
        tick();
        start = 1'b1;
        for (int i = 0; i < LAT - 2; i++) begin
            #1 chk("lit_resume_hold", int'(exmem_hold), 1);
            tick();
        end
        #1 chk("lit_resume_rel", int'(pc_write), 1);
        tick();

        // saturating counter
        clr();
        ifid_rs = 5'd7; idex_regwrite = 1'b1; idex_memread = 1'b1; idex_rd = 5'd7;
        repeat (CMAX + 5) tick();
        chk("lit_sat", int'(stall_cnt), CMAX);
        clr();
        tick();

        // reset mid-wait
        exmem_memacc = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1 chk("lit_arst_hold", int'(exmem_hold), 0);
        chk("lit_arst_cnt", int'(stall_cnt), 0);
        tick();
        rst = 1'b0;
        exmem_memacc = 1'b0;
        #1 chk("lit_post_pc", int'(pc_write), 1);
        chk("lit_post_cnt", int'(stall_cnt), 0);
        tick();
        exmem_memacc = 1'b1;
        #1 chk("lit_post_newacc", int'(exmem_hold), 1);
        tick();
        clr();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
